rom_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the instruction ROM's write port.
- Consumes a byte stream from the UART receiver and parses a framed image: magic byte, 16-bit word count, payload, checksum.
- Assembles payload bytes into little-endian 32-bit words and writes them into the ROM at consecutive word addresses.
- Holds the core in reset until a valid image has been loaded.

---
 rtl/rom_loader_pkg.sv | 32 +++
 rtl/rom_loader_pack.sv | 67 ++++++
 rtl/rom_loader.sv | 160 ++++++++++++++++
 tb/tb_rom_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the boot ROM loader.
//   - state_e        : loader FSM state encoding (3 bits)
//   - MAGIC_DEFAULT  : default frame start byte
//   - MEM_ADDR_W / WORD_W / ZERO_WORD : ROM write-port bus widths and zero word
//   - word_addr()    : byte address of a word index relative to a base
package rom_loader_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned WORD_W     = 32;
   localparam logic [WORD_W-1:0] ZERO_WORD = '0;
   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CKSUM = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   // Word index is zero-extended and scaled to a byte address; the length
   // limit keeps the sum from ever wrapping.
   function automatic logic [MEM_ADDR_W-1:0] word_addr(
      input logic [MEM_ADDR_W-1:0] base,
      input logic [15:0]           idx
   );
      return base + {14'b0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/rom_loader_pack.sv
// rom_loader_pack: byte-to-word packer for the ROM loader.
// Collects four bytes little-endian (first byte -> bits 7:0) and emits a
// registered one-cycle write strobe with the completed word.
// Ports:
//   clk, rst   : clock, async active-high reset
//   clr_i      : synchronous clear of the lane counter and partial word
//   push_i     : byte_i is consumed this cycle
//   byte_i     : payload byte
//   last_o     : the next pushed byte completes a word (lane 3)
//   wr_o       : word_o valid, high for one cycle after the 4th byte
//   word_o     : completed word {b3,b2,b1,b0}
module rom_loader_pack
   import rom_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic [7:0]        byte_i,
   output logic              last_o,
   output logic              wr_o,
   output logic [WORD_W-1:0] word_o
);

   logic [1:0]        lane_q,  lane_d;
   logic [23:0]       shift_q, shift_d;   // bytes 0..2 of the word in flight
   logic              wr_q,    wr_d;
   logic [WORD_W-1:0] word_q,  word_d;

   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      wr_d    = 1'b0;
      word_d  = word_q;
      if (clr_i) begin
         lane_d  = 2'd0;
         shift_d = '0;
      end else if (push_i) begin
         // Shift right so the earliest byte lands in the low lane.
         shift_d = {byte_i, shift_q[23:8]};
         lane_d  = lane_q + 2'd1;
         if (lane_q == 2'd3) begin
            wr_d   = 1'b1;
            word_d = {byte_i, shift_q};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q  <= 2'd0;
         shift_q <= '0;
         wr_q    <= 1'b0;
         word_q  <= ZERO_WORD;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
         wr_q    <= wr_d;
         word_q  <= word_d;
      end
   end

   assign last_o = (lane_q == 2'd3);
   assign wr_o   = wr_q;
   assign word_o = word_q;

endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot-time program loader feeding the instruction ROM write port.
// Parses MAGIC | len[7:0] | len[15:8] | len*4 payload bytes | checksum,
// writes payload words to consecutive addresses from BASE_ADDR and holds the
// core in reset until an image with a matching checksum has been loaded.
// Ports:
//   clk, rst                : clock, async active-high reset
//   byte_i/byte_valid_i     : UART byte stream in
//   byte_ready_o            : loader accepts byte_i (low in DONE/ERR)
//   start_i                 : re-arm from DONE or ERR
//   w_en_o/w_addr_o/w_data_o/w_sel_o : ROM write port
//   cpu_hold_o              : core reset hold
//   busy_o/done_o/err_o     : frame status
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned           MAX_WORDS = 16384,
   parameter logic [7:0]            MAGIC     = MAGIC_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   input  logic                  start_i,
   output logic                  w_en_o,
   output logic [MEM_ADDR_W-1:0] w_addr_o,
   output logic [WORD_W-1:0]     w_data_o,
   output logic [3:0]            w_sel_o,
   output logic                  cpu_hold_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   state_e                state_q, state_d;
   logic [15:0]           len_q,   len_d;
   logic [15:0]           idx_q,   idx_d;
   logic [7:0]            cks_q,   cks_d;
   logic                  hold_q,  hold_d;
   logic [MEM_ADDR_W-1:0] addr_q,  addr_d;

   logic        accept;
   logic        push;
   logic        rearm;
   logic        last;
   logic [15:0] len_full;

   assign byte_ready_o = (state_q != ST_DONE) && (state_q != ST_ERR);
   assign accept       = byte_valid_i && byte_ready_o;
   assign push         = accept && (state_q == ST_DATA);
   assign rearm        = start_i && ((state_q == ST_DONE) || (state_q == ST_ERR));
   assign len_full     = {byte_i, len_q[7:0]};

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cks_d   = cks_q;
      hold_d  = hold_q;
      addr_d  = addr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && byte_i == MAGIC) state_d = ST_LEN0;
         end
         ST_LEN0: begin
            if (accept) begin
               len_d[7:0] = byte_i;
               state_d    = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (accept) begin
               len_d = len_full;
               if ({16'b0, len_full} > 32'(MAX_WORDS)) begin
                  state_d = ST_ERR;
                  hold_d  = 1'b1;
               end else if (len_full == 16'd0) begin
                  state_d = ST_CKSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               cks_d = cks_q + byte_i;
               if (last) begin
                  // Address is captured alongside the packer's word so both
                  // appear together in the write cycle.
                  addr_d = word_addr(BASE_ADDR, idx_q);
                  idx_d  = idx_q + 16'd1;
                  if (idx_q + 16'd1 == len_q) state_d = ST_CKSUM;
               end
            end
         end
         ST_CKSUM: begin
            if (accept) begin
               if (byte_i == cks_q) begin
                  state_d = ST_DONE;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_ERR;
                  hold_d  = 1'b1;
               end
            end
         end
         ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d = ST_IDLE;
               idx_d   = 16'd0;
               cks_d   = 8'd0;
               hold_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         cks_q   <= 8'd0;
         hold_q  <= 1'b1;
         addr_q  <= BASE_ADDR;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cks_q   <= cks_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
      end
   end

   rom_loader_pack u_pack (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (rearm),
      .push_i (push),
      .byte_i (byte_i),
      .last_o (last),
      .wr_o   (w_en_o),
      .word_o (w_data_o)
   );

   assign w_addr_o   = addr_q;
   assign w_sel_o    = {4{w_en_o}};
   assign cpu_hold_o = hold_q;
   assign busy_o     = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                       (state_q == ST_DATA) || (state_q == ST_CKSUM);
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = (state_q == ST_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed self-checking bench for rom_loader.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_i = 8'h00;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o;
   logic        start_i = 1'b0;
   logic        w_en_o;
   logic [31:0] w_addr_o;
   logic [31:0] w_data_o;
   logic [3:0]  w_sel_o;
   logic        cpu_hold_o, busy_o, done_o, err_o;

   int errs   = 0;
   int checks = 0;
   int sel_bad = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [3:0]  wr_sel[$];

   rom_loader dut (
      .clk          (clk),
      .rst          (rst),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .start_i      (start_i),
      .w_en_o       (w_en_o),
      .w_addr_o     (w_addr_o),
      .w_data_o     (w_data_o),
      .w_sel_o      (w_sel_o),
      .cpu_hold_o   (cpu_hold_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   // Write monitor: every cycle with w_en_o high logs one write, so a
   // stretched pulse shows up as an extra entry.
   always @(negedge clk) begin
      if (w_en_o) begin
         wr_addr.push_back(w_addr_o);
         wr_data.push_back(w_data_o);
         wr_sel.push_back(w_sel_o);
      end else if (w_sel_o != 4'h0) begin
         sel_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Send one byte after `gap` idle cycles; waits (bounded) for ready.
   task automatic send(input logic [7:0] b, input int gap = 0);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      byte_i = b;
      byte_valid_i = 1'b1;
      n = 0;
      while (!byte_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic rearm();
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic clr_log();
      wr_addr.delete();
      wr_data.delete();
      wr_sel.delete();
   endtask

   initial begin
      #12;
      // Reset state
      chk("rst_wen",   {31'b0, w_en_o}, 32'd0);
      chk("rst_addr",  w_addr_o, 32'h0);
      chk("rst_data",  w_data_o, 32'h0);
      chk("rst_sel",   {28'b0, w_sel_o}, 32'd0);
      chk("rst_hold",  {31'b0, cpu_hold_o}, 32'd1);
      chk("rst_busy",  {31'b0, busy_o}, 32'd0);
      chk("rst_done",  {31'b0, done_o}, 32'd0);
      chk("rst_err",   {31'b0, err_o}, 32'd0);
      chk("rst_ready", {31'b0, byte_ready_o}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Good 2-word frame; payload sum 0x78+..+0xDE = 0x44C -> 0x4C
      send(8'hA5); send(8'h02); send(8'h00);
      chk("a_busy", {31'b0, busy_o}, 32'd1);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      send(8'h4C);
      chk("a_nwr", wr_addr.size(), 32'd2);
      if (wr_addr.size() == 2) begin
         chk("a_addr0", wr_addr[0], 32'h0);
         chk("a_data0", wr_data[0], 32'h1234_5678);
         chk("a_sel0",  {28'b0, wr_sel[0]}, 32'hF);
         chk("a_addr1", wr_addr[1], 32'h4);
         chk("a_data1", wr_data[1], 32'hDEAD_BEEF);
         chk("a_sel1",  {28'b0, wr_sel[1]}, 32'hF);
      end
      chk("a_done",  {31'b0, done_o}, 32'd1);
      chk("a_hold",  {31'b0, cpu_hold_o}, 32'd0);
      chk("a_busy2", {31'b0, busy_o}, 32'd0);
      chk("a_ready", {31'b0, byte_ready_o}, 32'd0);
      rearm();
      chk("a_rearm_hold", {31'b0, cpu_hold_o}, 32'd1);
      chk("a_rearm_done", {31'b0, done_o}, 32'd0);
      clr_log();

      // Bad checksum: writes still happen, then ERR
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      send(8'h29);
      chk("b_nwr", wr_addr.size(), 32'd2);
      if (wr_addr.size() == 2) begin
         chk("b_data0", wr_data[0], 32'h1234_5678);
         chk("b_addr1", wr_addr[1], 32'h4);
      end
      chk("b_err",   {31'b0, err_o}, 32'd1);
      chk("b_hold",  {31'b0, cpu_hold_o}, 32'd1);
      chk("b_ready", {31'b0, byte_ready_o}, 32'd0);
      rearm();
      chk("b_err2",   {31'b0, err_o}, 32'd0);
      chk("b_ready2", {31'b0, byte_ready_o}, 32'd1);
      clr_log();

      // Garbage before magic, then 1-word frame; sum DD+CC+BB+AA = 0x30E -> 0x0E
      send(8'h00); send(8'hFF); send(8'h5A);
      chk("c_idle", {31'b0, busy_o}, 32'd0);
      chk("c_nwr0", wr_addr.size(), 32'd0);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
      send(8'h0E);
      chk("c_nwr", wr_addr.size(), 32'd1);
      if (wr_addr.size() == 1) begin
         chk("c_addr", wr_addr[0], 32'h0);
         chk("c_data", wr_data[0], 32'hAABB_CCDD);
      end
      chk("c_done", {31'b0, done_o}, 32'd1);
      rearm();
      clr_log();

      // Oversize length 0x4001
      send(8'hA5); send(8'h01); send(8'h40);
      chk("d_err",  {31'b0, err_o}, 32'd1);
      chk("d_hold", {31'b0, cpu_hold_o}, 32'd1);
      repeat (2) @(negedge clk);
      chk("d_nwr", wr_addr.size(), 32'd0);
      rearm();

      // Max length 0x4000 is accepted (enters DATA, not ERR)
      send(8'hA5); send(8'h00); send(8'h40);
      chk("d_max_err",  {31'b0, err_o}, 32'd0);
      chk("d_max_busy", {31'b0, busy_o}, 32'd1);
      rst = 1'b1;
      #3;
      rst = 1'b0;
      clr_log();

      // Zero length: good then bad checksum
      send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      chk("e_done", {31'b0, done_o}, 32'd1);
      chk("e_nwr",  wr_addr.size(), 32'd0);
      rearm();
      send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
      chk("e_err", {31'b0, err_o}, 32'd1);
      rearm();
      clr_log();

      // Async reset mid word 1, with valid gaps
      send(8'hA5, 1); send(8'h02, 2); send(8'h00, 1);
      send(8'h01, 3); send(8'h02); send(8'h03, 2); send(8'h04);
      send(8'hEE, 2); send(8'hFF);
      chk("f_nwr_pre", wr_addr.size(), 32'd1);
      if (wr_addr.size() == 1) chk("f_data_pre", wr_data[0], 32'h0403_0201);
      chk("f_addr_pre", w_addr_o, 32'h0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("f_rst_busy", {31'b0, busy_o}, 32'd0);
      chk("f_rst_hold", {31'b0, cpu_hold_o}, 32'd1);
      chk("f_rst_data", w_data_o, 32'h0);
      chk("f_rst_wen",  {31'b0, w_en_o}, 32'd0);
      #2;
      rst = 1'b0;
      clr_log();
      // Fresh frame; sum 11+22+33+44 = 0xAA
      send(8'hA5, 2); send(8'h01); send(8'h00, 1);
      send(8'h11); send(8'h22, 3); send(8'h33); send(8'h44, 1);
      send(8'hAA);
      chk("f_nwr", wr_addr.size(), 32'd1);
      if (wr_addr.size() == 1) begin
         chk("f_addr", wr_addr[0], 32'h0);
         chk("f_data", wr_data[0], 32'h4433_2211);
      end
      chk("f_done", {31'b0, done_o}, 32'd1);
      chk("sel_idle", sel_bad, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
